mem2io_bridge: RTL and testbench

Parametrised memory/I-O bridge between the SLC-3 CPU bus (MAR/MDR side) and external SRAM plus board I/O. It replaces the fixed single-cycle Mem2IO path with a request/ready handshake, a configurable SRAM wait-state sequencer, a generalised memory-mapped I/O window (switches, LEDs, up to 8 hex digits) and a switch synchroniser. The block sits between the datapath and the top-level pins; hex nibbles feed external HexDriver instances.

---
 rtl/mem2io_bridge_pkg.sv | 22 ++
 rtl/mem2io_bridge_sync2.sv | 27 ++
 rtl/mem2io_bridge.sv | 168 ++++++++++++++++
 tb/tb_mem2io_bridge.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem2io_bridge_pkg.sv
// Shared types and constants for the SLC-3 memory/I-O bridge.
package mem2io_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Word offsets inside the 16-word I/O window.
  localparam logic [3:0] OFF_SW_HEX0 = 4'hF;
  localparam logic [3:0] OFF_HEX1    = 4'hE;
  localparam logic [3:0] OFF_LED     = 4'hD;

  // Each hex register holds four nibbles.
  localparam int unsigned HEX_REG_W  = 16;

  // Wait-state counter covers 0..15.
  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/mem2io_bridge_sync2.sv
// Two-flop synchroniser for asynchronous board inputs (switches).
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Capture the raw input, then re-register it to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem2io_bridge.sv
// Request/ready bridge from the SLC-3 MAR/MDR bus to external SRAM and a
// small memory-mapped I/O window (switches, LEDs, hex digits).
module mem2io_bridge
  import mem2io_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 16,
  parameter logic [ADDR_W-1:0] IO_BASE     = 16'hFFF0,
  parameter int unsigned       NUM_HEX     = 4,
  parameter int unsigned       SW_W        = 10,
  parameter int unsigned       LED_W       = 10,
  parameter int unsigned       WAIT_STATES = 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic [DATA_W-1:0]    cpu_rdata,
  output logic                 cpu_ready,
  output logic                 cpu_busy,
  input  logic [SW_W-1:0]      SW,
  output logic [LED_W-1:0]     LED,
  output logic [4*NUM_HEX-1:0] hex_digits,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [DATA_W-1:0]    sram_wdata,
  input  logic [DATA_W-1:0]    sram_rdata,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [HEX_REG_W-1:0]  hex0_q, hex0_d;
  logic [HEX_REG_W-1:0]  hex1_q, hex1_d;
  logic [LED_W-1:0]      led_q, led_d;

  logic [SW_W-1:0]       sw_sync;
  logic                  io_hit;
  logic [3:0]            io_off;
  logic [DATA_W-1:0]     io_rdata;

  // Switches are asynchronous to Clk; only the synchronised copy is read.
  sync2 #(.W(SW_W)) u_sw_sync (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .d_i    (SW),
    .q_o    (sw_sync)
  );

  // The I/O window is 16 words aligned on IO_BASE, so only the upper bits decide.
  assign io_hit = (cpu_addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
  assign io_off = cpu_addr[3:0];

  // Read mux for the I/O window; unmapped offsets and an absent hex reg 1 read 0.
  always_comb begin
    io_rdata = '0;
    case (io_off)
      OFF_SW_HEX0: io_rdata = DATA_W'(sw_sync);
      OFF_HEX1:    if (NUM_HEX > 4) io_rdata = DATA_W'(hex1_q);
      OFF_LED:     io_rdata = DATA_W'(led_q);
      default:     io_rdata = '0;
    endcase
  end

  // Sequencer next state plus latching of the request and I/O register writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex0_d  = hex0_q;
    hex1_d  = hex1_q;
    led_d   = led_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          if (io_hit) begin
            // I/O completes on the accepting edge; only the ready pulse follows.
            state_d = DONE;
            if (cpu_we) begin
              case (io_off)
                OFF_SW_HEX0: hex0_d = HEX_REG_W'(cpu_wdata);
                OFF_HEX1:    if (NUM_HEX > 4) hex1_d = HEX_REG_W'(cpu_wdata);
                OFF_LED:     led_d = cpu_wdata[LED_W-1:0];
                default:     led_d = led_q;
              endcase
            end else begin
              rdata_d = io_rdata;
            end
          end else begin
            state_d = ACCESS;
            cnt_d   = WAIT_CNT_W'(WAIT_STATES);
          end
        end
      end
      ACCESS: begin
        // Strobe stays low until the counter has run down through zero.
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) rdata_d = sram_rdata;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      DONE: begin
        // Requests seen here are dropped; the next one is taken in IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and I/O registers; reset aborts any access in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hex0_q  <= '0;
      hex1_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      led_q   <= led_d;
    end
  end

  // Outputs decode straight from registered state so reset forces them at once.
  assign cpu_ready  = (state_q == DONE);
  assign cpu_busy   = (state_q != IDLE);
  assign sram_oe_n  = !((state_q == ACCESS) && !we_q);
  assign sram_we_n  = !((state_q == ACCESS) && we_q);
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign cpu_rdata  = rdata_q;
  assign LED        = led_q;

  // Digits 0-3 come from hex reg 0, digits 4-7 from hex reg 1.
  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
    if (k < 4) begin : g_lo
      assign hex_digits[4*k +: 4] = hex0_q[4*k +: 4];
    end else begin : g_hi
      assign hex_digits[4*k +: 4] = hex1_q[4*(k-4) +: 4];
    end
  end

endmodule

// File: tb/tb_mem2io_bridge.sv
// Bench for mem2io_bridge: two instances (WS=2/4 digits, WS=0/8 digits) share
// one stimulus stream; a transaction-timeline model is compared every cycle.
module tb_mem2io_bridge;

  localparam int WS_A = 2;
  localparam int NH_A = 4;
  localparam int WS_B = 0;
  localparam int NH_B = 8;

  logic        Clk     = 1'b0;
  logic        Reset_n = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we  = 1'b0;
  logic [15:0] cpu_addr  = '0;
  logic [15:0] cpu_wdata = '0;
  logic [9:0]  SW = '0;

  logic [15:0] o_rd   [2];
  logic        o_rdy  [2];
  logic        o_busy [2];
  logic [9:0]  o_led  [2];
  logic [15:0] o_saddr[2];
  logic [15:0] o_swd  [2];
  logic [15:0] srd    [2];
  logic        o_oe   [2];
  logic        o_we   [2];
  logic [15:0] hex_a;
  logic [31:0] hex_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  // SRAM contents: a fixed function of the address.
  function automatic logic [15:0] sram_f(input logic [15:0] a);
    return (a == 16'h0042) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  assign srd[0] = sram_f(o_saddr[0]);
  assign srd[1] = sram_f(o_saddr[1]);

  mem2io_bridge #(.WAIT_STATES(WS_A), .NUM_HEX(NH_A)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(o_rd[0]),
    .cpu_ready(o_rdy[0]), .cpu_busy(o_busy[0]), .SW(SW), .LED(o_led[0]),
    .hex_digits(hex_a), .sram_addr(o_saddr[0]), .sram_wdata(o_swd[0]),
    .sram_rdata(srd[0]), .sram_oe_n(o_oe[0]), .sram_we_n(o_we[0])
  );

  mem2io_bridge #(.WAIT_STATES(WS_B), .NUM_HEX(NH_B)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(o_rd[1]),
    .cpu_ready(o_rdy[1]), .cpu_busy(o_busy[1]), .SW(SW), .LED(o_led[1]),
    .hex_digits(hex_b), .sram_addr(o_saddr[1]), .sram_wdata(o_swd[1]),
    .sram_rdata(srd[1]), .sram_oe_n(o_oe[1]), .sram_we_n(o_we[1])
  );

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, m, act, exp, $time);
    end
  endtask

  // ---------------- model: per instance, cycles elapsed since acceptance ----
  int          t_m   [2];   // 0 = idle, k = k-th cycle after accept edge
  int          len_m [2];   // cycle in which ready is due
  logic        io_m  [2];
  logic        we_m  [2];
  logic [15:0] addr_m[2], wd_m[2], rd_m[2], hex0_m[2], hex1_m[2];
  logic [9:0]  led_m [2];
  logic [9:0]  sw_h1, sw_h2;  // SW one and two edges ago

  function automatic int ws_of(input int m);
    return (m == 0) ? WS_A : WS_B;
  endfunction
  function automatic int nh_of(input int m);
    return (m == 0) ? NH_A : NH_B;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_h1 <= '0;
      sw_h2 <= '0;
      for (int m = 0; m < 2; m++) begin
        t_m[m] <= 0;  len_m[m] <= 0;  io_m[m] <= 1'b0;  we_m[m] <= 1'b0;
        addr_m[m] <= '0;  wd_m[m] <= '0;  rd_m[m] <= '0;
        hex0_m[m] <= '0;  hex1_m[m] <= '0;  led_m[m] <= '0;
      end
    end else begin
      sw_h1 <= SW;
      sw_h2 <= sw_h1;
      for (int m = 0; m < 2; m++) begin
        if (t_m[m] == 0) begin
          if (cpu_req) begin
            t_m[m] <= 1;  we_m[m] <= cpu_we;  addr_m[m] <= cpu_addr;  wd_m[m] <= cpu_wdata;
            if (cpu_addr >= 16'hFFF0) begin
              io_m[m] <= 1'b1;  len_m[m] <= 1;
              if (cpu_we) begin
                if (cpu_addr == 16'hFFFF) hex0_m[m] <= cpu_wdata;
                else if (cpu_addr == 16'hFFFE && nh_of(m) > 4) hex1_m[m] <= cpu_wdata;
                else if (cpu_addr == 16'hFFFD) led_m[m] <= cpu_wdata[9:0];
              end else begin
                if (cpu_addr == 16'hFFFF) rd_m[m] <= {6'b0, sw_h2};
                else if (cpu_addr == 16'hFFFE) rd_m[m] <= (nh_of(m) > 4) ? hex1_m[m] : 16'h0;
                else if (cpu_addr == 16'hFFFD) rd_m[m] <= {6'b0, led_m[m]};
                else rd_m[m] <= 16'h0;
              end
            end else begin
              io_m[m] <= 1'b0;  len_m[m] <= ws_of(m) + 2;
            end
          end
        end else if (t_m[m] == len_m[m]) begin
          t_m[m] <= 0;
        end else begin
          if (!io_m[m] && !we_m[m] && t_m[m] == len_m[m] - 1) rd_m[m] <= sram_f(addr_m[m]);
          t_m[m] <= t_m[m] + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare --------------------------------------
  always @(negedge Clk) begin
    bit          on;
    logic [31:0] hx, hxe;
    for (int m = 0; m < 2; m++) begin
      on  = (t_m[m] != 0) && !io_m[m] && (t_m[m] < len_m[m]);
      hx  = (m == 0) ? {16'h0, hex_a} : hex_b;
      hxe = (m == 0) ? {16'h0, hex0_m[m]} : {hex1_m[m], hex0_m[m]};
      chk("cyc_ready", m, o_rdy[m], (t_m[m] != 0) && (t_m[m] == len_m[m]));
      chk("cyc_busy",  m, o_busy[m], t_m[m] != 0);
      chk("cyc_oe_n",  m, o_oe[m], !(on && !we_m[m]));
      chk("cyc_we_n",  m, o_we[m], !(on && we_m[m]));
      chk("cyc_rdata", m, o_rd[m], rd_m[m]);
      chk("cyc_led",   m, o_led[m], led_m[m]);
      chk("cyc_hex",   m, hx, hxe);
      if (on) begin
        chk("cyc_sram_addr", m, o_saddr[m], addr_m[m]);
        if (we_m[m]) chk("cyc_sram_wdata", m, o_swd[m], wd_m[m]);
      end
    end
  end

  // ---------------- directed stimulus --------------------------------------
  int rk [2];   // first cycle with ready
  int rn [2];   // number of ready pulses
  int oec[2];   // cycles with sram_oe_n low
  int wec[2];   // cycles with sram_we_n low

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic clr_stats();
    for (int m = 0; m < 2; m++) begin
      rk[m] = 0;  rn[m] = 0;  oec[m] = 0;  wec[m] = 0;
    end
  endtask

  task automatic sample(input int k);
    for (int m = 0; m < 2; m++) begin
      if (!o_oe[m]) oec[m]++;
      if (!o_we[m]) wec[m]++;
      if (o_rdy[m]) begin
        rn[m]++;
        if (rk[m] == 0) rk[m] = k;
      end
    end
  endtask

  // One-cycle request, then observe cycles 1..7 after the accepting edge.
  task automatic txn(input logic we, input logic [15:0] a, input logic [15:0] d);
    cpu_req = 1'b1;  cpu_we = we;  cpu_addr = a;  cpu_wdata = d;
    cyc();
    cpu_req = 1'b0;
    clr_stats();
    for (int k = 1; k <= 7; k++) begin
      sample(k);
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 Reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_oe_n",  0, o_oe[0], 1'b1);
    chk("rst_ready", 0, o_rdy[0], 1'b0);
    chk("rst_rdata", 1, o_rd[1], 16'h0);
    chk("rst_hex",   1, hex_b, 32'h0);
    Reset_n = 1'b1;
    SW = 10'h2A5;
    repeat (3) cyc();

    // SRAM read of 0x0042
    txn(1'b0, 16'h0042, 16'h0);
    chk("rd_ready_cycle", 0, rk[0], 4);
    chk("rd_oe_cycles",   0, oec[0], 3);
    chk("rd_ready_count", 0, rn[0], 1);
    chk("rd_data",        0, o_rd[0], 16'hBEEF);
    chk("rd_ready_cycle", 1, rk[1], 2);
    chk("rd_oe_cycles",   1, oec[1], 1);
    chk("rd_data",        1, o_rd[1], 16'hBEEF);
    chk("rd_we_cycles",   0, wec[0], 0);

    // SRAM write 0x1000 = 0x1234
    txn(1'b1, 16'h1000, 16'h1234);
    chk("wr_we_cycles",   1, wec[1], 1);
    chk("wr_oe_cycles",   1, oec[1], 0);
    chk("wr_ready_cycle", 1, rk[1], 2);
    chk("wr_we_cycles",   0, wec[0], 3);
    chk("wr_ready_cycle", 0, rk[0], 4);

    // I/O: switches and hex reg 0
    txn(1'b0, 16'hFFFF, 16'h0);
    chk("sw_ready_cycle", 0, rk[0], 1);
    chk("sw_ready_cycle", 1, rk[1], 1);
    chk("sw_rdata",       0, o_rd[0], 16'h02A5);
    txn(1'b1, 16'hFFFF, 16'hCAFE);
    chk("hex0_a",         0, hex_a, 16'hCAFE);
    chk("hex0_b",         1, hex_b, 32'h0000CAFE);
    chk("io_no_strobe",   0, oec[0] + wec[0], 0);

    // Hex reg 1 (only present with 8 digits)
    txn(1'b1, 16'hFFFE, 16'h0123);
    txn(1'b1, 16'hFFFF, 16'h4567);
    chk("hex8",           1, hex_b, 32'h01234567);
    chk("hex4",           0, hex_a, 16'h4567);
    txn(1'b0, 16'hFFFE, 16'h0);
    chk("hex1_rd_absent", 0, o_rd[0], 16'h0);
    chk("hex1_rd",        1, o_rd[1], 16'h0123);

    // LED register
    txn(1'b1, 16'hFFFD, 16'hFFFF);
    chk("led",            0, o_led[0], 10'h3FF);
    txn(1'b0, 16'hFFFD, 16'h0);
    chk("led_rd",         1, o_rd[1], 16'h03FF);

    // Unmapped offset reads 0
    txn(1'b0, 16'hFFF3, 16'h0);
    chk("unmapped_rd",    0, o_rd[0], 16'h0);

    // Switch change is seen by reads two edges later
    SW = 10'h155;
    cyc();
    txn(1'b0, 16'hFFFF, 16'h0);
    chk("sw_sync_old",    0, o_rd[0], 16'h02A5);
    txn(1'b0, 16'hFFFF, 16'h0);
    chk("sw_sync_new",    1, o_rd[1], 16'h0155);

    // Busy rule: extra requests in ACCESS/DONE are dropped
    cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 16'h0042;
    cyc();
    clr_stats();
    cpu_addr = 16'h0077;
    for (int k = 1; k <= 10; k++) begin
      sample(k);
      cpu_req = (k == 1 || k == 2 || k == 4);
      cyc();
    end
    cpu_req = 1'b0;
    chk("busy_ready_count", 0, rn[0], 1);
    chk("busy_ready_count", 1, rn[1], 2);
    chk("busy_rdata",       0, o_rd[0], 16'hBEEF);
    chk("busy_rdata",       1, o_rd[1], 16'h5A2D);

    // Reset in the middle of an SRAM write
    cpu_req = 1'b1;  cpu_we = 1'b1;  cpu_addr = 16'h2000;  cpu_wdata = 16'h5555;
    cyc();
    cpu_req = 1'b0;
    chk("pre_rst_we_n", 0, o_we[0], 1'b0);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_we_n", 0, o_we[0], 1'b1);
    chk("mid_rst_we_n", 1, o_we[1], 1'b1);
    chk("mid_rst_led",  0, o_led[0], 10'h0);
    chk("mid_rst_hex",  1, hex_b, 32'h0);
    chk("mid_rst_busy", 0, o_busy[0], 1'b0);
    clr_stats();
    for (int k = 1; k <= 3; k++) begin
      cyc();
      sample(k);
    end
    Reset_n = 1'b1;
    for (int k = 4; k <= 9; k++) begin
      cyc();
      sample(k);
    end
    chk("rst_no_ready", 0, rn[0], 0);
    chk("rst_no_ready", 1, rn[1], 0);

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
